pipe_stage_buffer: RTL and testbench

Parametrised successor to the fixed ID/EX-style pipeline register. It provides one generic pipeline stage that carries a DATA_W payload word and a CTRL_W control bundle between two stages. It adds a valid/ready handshake, an optional skid entry for full throughput under back-pressure, synchronous flush with bubble insertion, and a saturating stall counter. It is instanced between any two processor stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_stage_buffer.sv | 206 ++++++++++++++++++++
 tb/tb_pipe_stage_buffer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buffer.sv
// ---------------------------------------------------------------------------
// pipe_stage_buffer
//
// Generic pipeline register placed between two processor stages (IF/ID,
// ID/EX, EX/MEM, MEM/WB). It carries a DATA_W payload and a CTRL_W control
// bundle under a valid/ready handshake. With SKID_EN=1 a second (skid)
// entry absorbs one extra instruction, which keeps full throughput when
// downstream back-pressure arrives. With SKID_EN=0 the stage holds a single
// entry and in_ready is combinational.
//
// All state updates on the FALLING edge of clk. reset is asynchronous and
// active-low.
//
// Ports:
//   clk        stage clock (state updates on the falling edge)
//   reset      asynchronous active-low reset
//   in_valid   upstream presents a valid instruction
//   in_ready   this stage accepts in_data/in_ctrl on this edge
//   in_data    upstream payload            [DATA_W]
//   in_ctrl    upstream control bundle     [CTRL_W]
//   out_valid  out_data/out_ctrl hold a valid instruction
//   out_ready  downstream consumes the output on this edge
//   out_data   registered payload          [DATA_W]
//   out_ctrl   registered control bundle, all-zero when out_valid=0
//   flush      synchronous squash of every held instruction
//   stall_cnt  saturating count of edges with out_valid & ~out_ready [CNT_W]
//   clr_cnt    synchronous clear of stall_cnt
// ---------------------------------------------------------------------------
module pipe_stage_buffer #(
    parameter int DATA_W  = 32,
    parameter int CTRL_W  = 10,
    parameter int SKID_EN = 1,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    input  logic              flush,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              clr_cnt
);

    // EMPTY: nothing held. FULL: main entry valid. SKID: main and skid valid.
    // SKID is unreachable when SKID_EN=0.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_stateNxt;

    logic [DATA_W-1:0]   r_mainData;
    logic [CTRL_W-1:0]   r_mainCtrl;
    logic [DATA_W-1:0]   r_skidData;
    logic [CTRL_W-1:0]   r_skidCtrl;

    logic [DATA_W-1:0]   w_mainDataNxt;
    logic [CTRL_W-1:0]   w_mainCtrlNxt;
    logic [DATA_W-1:0]   w_skidDataNxt;
    logic [CTRL_W-1:0]   w_skidCtrlNxt;

    // r_inReady is 0 throughout reset and becomes 1 on the first edge after
    // release; it then tracks "next state is not SKID".
    logic                r_inReady;
    logic                w_inReadyNxt;

    logic                w_accept;
    logic                w_consume;
    logic                w_stall;

    logic [CNT_W-1:0]    r_stallCnt;

    // Handshake events, evaluated for the coming falling edge.
    assign w_accept  = in_valid & in_ready;
    assign w_consume = out_valid & out_ready;
    assign w_stall   = out_valid & ~out_ready & ~flush;

    // State and entry registers. Reset clears everything immediately,
    // independent of the clock.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_EMPTY;
            r_mainData <= '0;
            r_mainCtrl <= '0;
            r_skidData <= '0;
            r_skidCtrl <= '0;
            r_inReady  <= 1'b0;
        end else begin
            r_state    <= w_stateNxt;
            r_mainData <= w_mainDataNxt;
            r_mainCtrl <= w_mainCtrlNxt;
            r_skidData <= w_skidDataNxt;
            r_skidCtrl <= w_skidCtrlNxt;
            r_inReady  <= w_inReadyNxt;
        end
    end

    // Next-state and entry-update logic. Flush wins over every transfer:
    // any accept on a flush edge is dropped (upstream squashes the same
    // instruction) and both entries are zeroed so no stale control survives.
    // Entries that become invalid are zeroed so that out_ctrl is a clean
    // bubble and the skid never holds leftover state.
    always_comb begin
        w_stateNxt    = r_state;
        w_mainDataNxt = r_mainData;
        w_mainCtrlNxt = r_mainCtrl;
        w_skidDataNxt = r_skidData;
        w_skidCtrlNxt = r_skidCtrl;

        if (flush) begin
            w_stateNxt    = ST_EMPTY;
            w_mainDataNxt = '0;
            w_mainCtrlNxt = '0;
            w_skidDataNxt = '0;
            w_skidCtrlNxt = '0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_mainDataNxt = in_data;
                        w_mainCtrlNxt = in_ctrl;
                        w_stateNxt    = ST_FULL;
                    end
                end

                ST_FULL: begin
                    if (w_consume && w_accept) begin
                        w_mainDataNxt = in_data;
                        w_mainCtrlNxt = in_ctrl;
                    end else if (w_consume) begin
                        w_mainDataNxt = '0;
                        w_mainCtrlNxt = '0;
                        w_stateNxt    = ST_EMPTY;
                    end else if (w_accept && (SKID_EN != 0)) begin
                        // Downstream is stalled but upstream already saw
                        // in_ready=1, so park the new instruction behind main.
                        w_skidDataNxt = in_data;
                        w_skidCtrlNxt = in_ctrl;
                        w_stateNxt    = ST_SKID;
                    end
                end

                ST_SKID: begin
                    // in_ready is 0 here, so no accept can occur alongside.
                    if (w_consume) begin
                        w_mainDataNxt = r_skidData;
                        w_mainCtrlNxt = r_skidCtrl;
                        w_skidDataNxt = '0;
                        w_skidCtrlNxt = '0;
                        w_stateNxt    = ST_FULL;
                    end
                end

                default: begin
                    w_stateNxt    = ST_EMPTY;
                    w_mainDataNxt = '0;
                    w_mainCtrlNxt = '0;
                    w_skidDataNxt = '0;
                    w_skidCtrlNxt = '0;
                end
            endcase
        end

        // Registered ready: upstream may send whenever the skid is free.
        w_inReadyNxt = (w_stateNxt != ST_SKID);
    end

    // Output decode. With a skid the ready is purely registered so it never
    // forms a combinational path from out_ready. Without a skid the single
    // entry can only take a new word if it drains on the same edge.
    // r_inReady still gates the no-skid ready so in_ready is low in reset.
    always_comb begin
        out_valid = (r_state != ST_EMPTY);
        out_data  = r_mainData;
        out_ctrl  = (r_state != ST_EMPTY) ? r_mainCtrl : '0;
        if (SKID_EN != 0) begin
            in_ready = r_inReady;
        end else begin
            in_ready = r_inReady & (out_ready | (r_state == ST_EMPTY));
        end
    end

    // Stall counter: clear beats increment, saturates at all-ones, and is
    // left untouched by flush so hazard statistics survive squashes.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            r_stallCnt <= '0;
        end else if (clr_cnt) begin
            r_stallCnt <= '0;
        end else if (w_stall && (r_stallCnt != {CNT_W{1'b1}})) begin
            r_stallCnt <= r_stallCnt + CNT_W'(1);
        end
    end

    assign stall_cnt = r_stallCnt;

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_buffer
//
// Scoreboard bench for pipe_stage_buffer. Two instances share the clock and
// reset: dut (SKID_EN=1, CNT_W=4) and dutNs (SKID_EN=0, CNT_W=16).
// Stimulus tasks push the expected word whenever a handshake is expected to
// complete; independent monitors pop and compare whenever a DUT presents a
// consumed output. Inputs change on the rising edge; the DUT acts on the
// falling edge; checks sample a little after the rising edge.
// ---------------------------------------------------------------------------
module tb_pipe_stage_buffer;

    typedef struct packed {
        logic [9:0]  ctrl;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        reset;

    logic        in_valid, in_ready, out_valid, out_ready, flush, clr_cnt;
    logic [31:0] in_data, out_data;
    logic [9:0]  in_ctrl, out_ctrl;
    logic [3:0]  stall_cnt;

    logic        in_valid2, in_ready2, out_valid2, out_ready2, flush2, clr_cnt2;
    logic [31:0] in_data2, out_data2;
    logic [9:0]  in_ctrl2, out_ctrl2;
    logic [15:0] stall_cnt2;

    exp_t        sbq[$];
    exp_t        sbq2[$];

    int          assertCount = 0;
    int          failCount   = 0;

    pipe_stage_buffer #(.DATA_W(32), .CTRL_W(10), .SKID_EN(1), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ctrl(out_ctrl),
        .flush(flush), .stall_cnt(stall_cnt), .clr_cnt(clr_cnt)
    );

    pipe_stage_buffer #(.DATA_W(32), .CTRL_W(10), .SKID_EN(0), .CNT_W(16)) dutNs (
        .clk(clk), .reset(reset),
        .in_valid(in_valid2), .in_ready(in_ready2),
        .in_data(in_data2), .in_ctrl(in_ctrl2),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .out_data(out_data2), .out_ctrl(out_ctrl2),
        .flush(flush2), .stall_cnt(stall_cnt2), .clr_cnt(clr_cnt2)
    );

    // Free-running clock: rising edges at 5, 15, ...; falling at 10, 20, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control bundle derived from the payload so ctrl ordering is checked too.
    function automatic logic [9:0] ctrlOf(input logic [31:0] d);
        return d[9:0] ^ 10'h155;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of stimulus to the skid instance, check the hand-
    // computed in_ready, and record the word if the handshake completes.
    task automatic applyStimulus(input logic v, input logic [31:0] d,
                                 input logic ordy, input logic fl,
                                 input logic clr, input logic expReady);
        @(posedge clk);
        in_valid  = v;
        in_data   = d;
        in_ctrl   = ctrlOf(d);
        out_ready = ordy;
        flush     = fl;
        clr_cnt   = clr;
        #1;
        checkOutput("in_ready", {31'd0, in_ready}, {31'd0, expReady});
        if (fl) sbq.delete();
        if (v && expReady && !fl) sbq.push_back('{ctrl: ctrlOf(d), data: d});
    endtask

    // Same for the no-skid instance.
    task automatic applyStimulusNs(input logic v, input logic [31:0] d,
                                   input logic ordy, input logic expReady);
        @(posedge clk);
        in_valid2  = v;
        in_data2   = d;
        in_ctrl2   = ctrlOf(d);
        out_ready2 = ordy;
        #1;
        checkOutput("in_ready_noskid", {31'd0, in_ready2}, {31'd0, expReady});
        if (v && expReady) sbq2.push_back('{ctrl: ctrlOf(d), data: d});
    endtask

    // Monitor for the skid instance: every consumed output must match the
    // oldest outstanding expected word; invalid outputs must be bubbles.
    always @(posedge clk) begin
        #2;
        if (reset && out_valid && out_ready && !flush) begin
            if (sbq.size() == 0) begin
                assertCount++;
                failCount++;
                $display("[TB] FAIL unexpected_output: got 0x%0h, expected none", out_data);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                checkOutput("out_data", out_data, e.data);
                checkOutput("out_ctrl", {22'd0, out_ctrl}, {22'd0, e.ctrl});
            end
        end
        if (!out_valid) checkOutput("bubble_ctrl", {22'd0, out_ctrl}, 32'd0);
    end

    // Monitor for the no-skid instance.
    always @(posedge clk) begin
        #2;
        if (reset && out_valid2 && out_ready2) begin
            if (sbq2.size() == 0) begin
                assertCount++;
                failCount++;
                $display("[TB] FAIL unexpected_output_noskid: got 0x%0h, expected none", out_data2);
            end else begin
                exp_t e;
                e = sbq2.pop_front();
                checkOutput("out_data_noskid", out_data2, e.data);
                checkOutput("out_ctrl_noskid", {22'd0, out_ctrl2}, {22'd0, e.ctrl});
            end
        end
        if (!out_valid2) checkOutput("bubble_ctrl_noskid", {22'd0, out_ctrl2}, 32'd0);
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        in_valid = 0; in_data = 0; in_ctrl = 0; out_ready = 0; flush = 0; clr_cnt = 0;
        in_valid2 = 0; in_data2 = 0; in_ctrl2 = 0; out_ready2 = 0; flush2 = 0; clr_cnt2 = 0;
        #1 reset = 1'b0;

        // Reset held for three cycles.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_out_data", out_data, 32'd0);
        checkOutput("rst_out_ctrl", {22'd0, out_ctrl}, 32'd0);
        checkOutput("rst_stall_cnt", {28'd0, stall_cnt}, 32'd0);
        checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("rst_in_ready_noskid", {31'd0, in_ready2}, 32'd0);
        reset = 1'b1;

        // Streaming at full rate: each word appears one edge after entry.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 32'h10 + i, 1'b1, 1'b0, 1'b0, 1'b1);
            if (i > 0) begin
                checkOutput("stream_valid", {31'd0, out_valid}, 32'd1);
                checkOutput("stream_data", out_data, 32'h10 + i - 1);
            end
        end
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("stream_last", out_data, 32'h14);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("stream_drained", {31'd0, out_valid}, 32'd0);
        checkOutput("stream_stall_cnt", {28'd0, stall_cnt}, 32'd0);

        // Back-pressure into the skid entry, then release.
        applyStimulus(1'b1, 32'hA0, 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'hA1, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'hA2, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("bp_hold_a0", out_data, 32'hA0);
        applyStimulus(1'b1, 32'hA2, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("bp_still_a0", out_data, 32'hA0);
        applyStimulus(1'b1, 32'hA2, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hA2, 1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("bp_a1", out_data, 32'hA1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("bp_a2", out_data, 32'hA2);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("bp_empty", {31'd0, out_valid}, 32'd0);
        checkOutput("bp_stall_cnt", {28'd0, stall_cnt}, 32'd3);

        // Flush while in SKID with a valid word on the input.
        applyStimulus(1'b1, 32'hB0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'hB1, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'hFF, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("flush_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("flush_ctrl", {22'd0, out_ctrl}, 32'd0);
        checkOutput("flush_data", out_data, 32'd0);
        checkOutput("flush_keeps_cnt", {28'd0, stall_cnt}, 32'd4);

        // Flush from FULL discards a simultaneous accept.
        applyStimulus(1'b1, 32'hC0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'hC1, 1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("flush_full_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("flush_full_cnt", {28'd0, stall_cnt}, 32'd4);

        // Counter saturation with a 20-edge stall, then clear under stall.
        applyStimulus(1'b1, 32'hD0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 20; k++) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("sat_cnt", {28'd0, stall_cnt}, 32'd15);
        checkOutput("sat_data_stable", out_data, 32'hD0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("clr_cnt", {28'd0, stall_cnt}, 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("cnt_after_clr", {28'd0, stall_cnt}, 32'd1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("cnt_before_drain", {28'd0, stall_cnt}, 32'd2);

        // Asynchronous reset between edges while in SKID.
        applyStimulus(1'b1, 32'hE0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'hE1, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'hE2, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        in_valid = 1'b0;
        out_ready = 1'b0;
        #1;
        checkOutput("pre_rst_data", out_data, 32'hE0);
        checkOutput("pre_rst_cnt", {28'd0, stall_cnt}, 32'd4);
        #2;
        reset = 1'b0;
        sbq.delete();
        #1;
        checkOutput("arst_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("arst_data", out_data, 32'd0);
        checkOutput("arst_ctrl", {22'd0, out_ctrl}, 32'd0);
        checkOutput("arst_cnt", {28'd0, stall_cnt}, 32'd0);
        checkOutput("arst_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        applyStimulus(1'b1, 32'hF0, 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("post_rst_data", out_data, 32'hF0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);

        // No-skid instance: in_ready follows out_ready while full.
        applyStimulusNs(1'b1, 32'h50, 1'b1, 1'b1);
        applyStimulusNs(1'b1, 32'h51, 1'b1, 1'b1);
        applyStimulusNs(1'b1, 32'h52, 1'b0, 1'b0);
        applyStimulusNs(1'b1, 32'h52, 1'b1, 1'b1);
        applyStimulusNs(1'b1, 32'h53, 1'b0, 1'b0);
        applyStimulusNs(1'b1, 32'h53, 1'b1, 1'b1);
        applyStimulusNs(1'b0, 32'h0, 1'b1, 1'b1);
        applyStimulusNs(1'b0, 32'h0, 1'b0, 1'b1);
        checkOutput("noskid_empty", {31'd0, out_valid2}, 32'd0);
        checkOutput("noskid_stall_cnt", {16'd0, stall_cnt2}, 32'd2);

        repeat (2) @(posedge clk);
        #3;
        checkOutput("sb_drained", sbq.size(), 32'd0);
        checkOutput("sb_drained_noskid", sbq2.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
